mem_responder: RTL and testbench

Memory-side responder for the core's instruction and data request ports. It answers `INSTR_REQ` with `INSTR_VALID` and `DATA_REQ`/`DATA_WRITE_ENABLE` with `DATA_VALID`, and serves both ports from one single-ported word RAM. Each response takes a programmable number of wait states. It sits between the core control/datapath and the on-chip memory array and is the far end of the core's request/valid handshake.

---
 rtl/mem_responder_pkg.sv | 33 +++
 rtl/mem_array.sv | 62 ++++++
 rtl/mem_responder.sv | 140 ++++++++++++++
 tb/tb_mem_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types, widths and the address-range fault check for mem_responder.
package mem_responder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_TURN = 2'd3
  } state_e;

  // Latched copy of the accepted request; the word index is held separately
  // because its width depends on the instance's ADDR_WIDTH.
  typedef struct packed {
    logic              is_data;
    logic              we;
    logic              fault;
    logic [WORD_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

  // A byte address faults when it is not word aligned or lies beyond the RAM.
  function automatic logic addr_fault(input logic [WORD_W-1:0] addr,
                                      input int unsigned       aw);
    logic [WORD_W-1:0] hi;
    hi = addr >> (aw + 32'd2);
    return (addr[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-ported word RAM: byte-lane synchronous write, synchronous read into
// one holding register per requesting port.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic                  rd_port,
  input  logic                  rd_zero,
  input  logic                  we,
  input  logic [BE_W-1:0]       be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     instr_rdata,
  output logic [WORD_W-1:0]     data_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rd_word_c;
  logic [WORD_W-1:0] instr_rdata_q, instr_rdata_d;
  logic [WORD_W-1:0] data_rdata_q, data_rdata_d;

  // Byte-enabled write; array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read word steered to the requesting port; stores and faults return zero.
  always_comb begin
    rd_word_c    = rd_zero ? '0 : mem[addr];
    instr_rdata_d = instr_rdata_q;
    data_rdata_d  = data_rdata_q;
    if (rd_en) begin
      if (rd_port) data_rdata_d  = rd_word_c;
      else         instr_rdata_d = rd_word_c;
    end
  end

  // Per-port read registers hold until that port's next response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      instr_rdata_q <= instr_rdata_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  assign instr_rdata = instr_rdata_q;
  assign data_rdata  = data_rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates instruction/data requests onto one RAM
// port, inserts programmable wait states and returns a one-cycle strobe.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              INSTR_REQ,
  input  logic [WORD_W-1:0] INSTR_ADDR,
  output logic              INSTR_VALID,
  output logic [WORD_W-1:0] INSTR_RDATA,
  input  logic              DATA_REQ,
  input  logic              DATA_WRITE_ENABLE,
  input  logic [WORD_W-1:0] DATA_ADDR,
  input  logic [WORD_W-1:0] DATA_WDATA,
  input  logic [BE_W-1:0]   DATA_BE,
  output logic              DATA_VALID,
  output logic [WORD_W-1:0] DATA_RDATA,
  output logic              ACC_ERR
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  req_t                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] word_q, word_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  data_valid_q, data_valid_d;
  logic                  acc_err_q, acc_err_d;

  logic                  ram_rd_en_c;
  logic                  ram_rd_zero_c;
  logic                  ram_we_c;

  // Next-state, request latch, wait counter and response strobes.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_d         = req_q;
    word_d        = word_q;
    instr_valid_d = 1'b0;
    data_valid_d  = 1'b0;
    acc_err_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (DATA_REQ) begin
          req_d   = '{is_data: 1'b1,
                      we:      DATA_WRITE_ENABLE,
                      fault:   addr_fault(DATA_ADDR, ADDR_WIDTH),
                      wdata:   DATA_WDATA,
                      be:      DATA_BE};
          word_d  = DATA_ADDR[ADDR_WIDTH+1:2];
          cnt_d   = '0;
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end else if (INSTR_REQ) begin
          req_d   = '{is_data: 1'b0,
                      we:      1'b0,
                      fault:   addr_fault(INSTR_ADDR, ADDR_WIDTH),
                      wdata:   '0,
                      be:      '0};
          word_d  = INSTR_ADDR[ADDR_WIDTH+1:2];
          cnt_d   = '0;
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_TURN;
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Strobes are registered so they line up with the RESP cycle.
    if (state_d == ST_RESP) begin
      instr_valid_d = ~req_d.is_data;
      data_valid_d  = req_d.is_data;
      acc_err_d     = req_d.fault;
    end
  end

  // FSM, latch and strobe registers.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      req_q         <= '0;
      word_q        <= '0;
      instr_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      acc_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_q         <= req_d;
      word_q        <= word_d;
      instr_valid_q <= instr_valid_d;
      data_valid_q  <= data_valid_d;
      acc_err_q     <= acc_err_d;
    end
  end

  // Read on entry to RESP, write at the end of RESP; never in the same cycle.
  always_comb begin
    ram_rd_en_c   = instr_valid_d | data_valid_d;
    ram_rd_zero_c = req_d.we | req_d.fault;
    ram_we_c      = (state_q == ST_RESP) & req_q.is_data & req_q.we & ~req_q.fault;
  end

  mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk         (CLK),
    .rst         (RES),
    .rd_en       (ram_rd_en_c),
    .rd_port     (req_d.is_data),
    .rd_zero     (ram_rd_zero_c),
    .we          (ram_we_c),
    .be          (req_q.be),
    .addr        (word_d),
    .wdata       (req_q.wdata),
    .instr_rdata (INSTR_RDATA),
    .data_rdata  (DATA_RDATA)
  );

  assign INSTR_VALID = instr_valid_q;
  assign DATA_VALID  = data_valid_q;
  assign ACC_ERR     = acc_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder with a word-array reference.
module tb_mem_responder;

  localparam int unsigned AW     = 10;
  localparam int unsigned W      = 2;
  localparam int unsigned NWORDS = 32;

  logic        CLK = 1'b0;
  logic        RES = 1'b1;
  logic        INSTR_REQ = 1'b0;
  logic [31:0] INSTR_ADDR = '0;
  logic        INSTR_VALID;
  logic [31:0] INSTR_RDATA;
  logic        DATA_REQ = 1'b0;
  logic        DATA_WRITE_ENABLE = 1'b0;
  logic [31:0] DATA_ADDR = '0;
  logic [31:0] DATA_WDATA = '0;
  logic [3:0]  DATA_BE = '0;
  logic        DATA_VALID;
  logic [31:0] DATA_RDATA;
  logic        ACC_ERR;

  mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
    .CLK               (CLK),
    .RES               (RES),
    .INSTR_REQ         (INSTR_REQ),
    .INSTR_ADDR        (INSTR_ADDR),
    .INSTR_VALID       (INSTR_VALID),
    .INSTR_RDATA       (INSTR_RDATA),
    .DATA_REQ          (DATA_REQ),
    .DATA_WRITE_ENABLE (DATA_WRITE_ENABLE),
    .DATA_ADDR         (DATA_ADDR),
    .DATA_WDATA        (DATA_WDATA),
    .DATA_BE           (DATA_BE),
    .DATA_VALID        (DATA_VALID),
    .DATA_RDATA        (DATA_RDATA),
    .ACC_ERR           (ACC_ERR)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned due;
  } exp_t;

  exp_t        iq[$];
  exp_t        dq[$];
  logic [31:0] ref_mem [NWORDS];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a >= (32'd1 << (AW + 2)));
  endfunction

  // Reference: apply the access to the word array, return the expected response.
  task automatic model_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] be, input int unsigned due, output exp_t e);
    logic [31:0] mask;
    e.due   = due;
    e.err   = is_fault(a);
    e.rdata = '0;
    if (!e.err) begin
      if (we) begin
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        ref_mem[a / 4] = (ref_mem[a / 4] & ~mask) | (wd & mask);
      end else begin
        e.rdata = ref_mem[a / 4];
      end
    end
  endtask

  function automatic logic [31:0] gen_addr();
    logic [31:0] word;
    word = 32'($urandom_range(0, NWORDS - 1)) * 4;
    if ($urandom_range(0, 7) != 0) return word;
    case ($urandom_range(0, 2))
      0:       return word + 32'($urandom_range(1, 3));
      1:       return 32'h0010_0000;
      default: return 32'h8000_0000 | word;
    endcase
  endfunction

  // Monitor: every strobe pops the matching port queue and is compared.
  always @(negedge CLK) begin
    exp_t e;
    if (!RES) begin
      chk("strobe_overlap", 32'(INSTR_VALID & DATA_VALID), 32'd0);
      if (ACC_ERR && !INSTR_VALID && !DATA_VALID) chk("err_without_valid", 32'(ACC_ERR), 32'd0);
      if (INSTR_VALID) begin
        if (iq.size() == 0) chk("instr_unexpected", 32'(INSTR_VALID), 32'd0);
        else begin
          e = iq.pop_front();
          chk("instr_rdata", INSTR_RDATA, e.rdata);
          chk("instr_err", 32'(ACC_ERR), 32'(e.err));
          chk("instr_cycle", cyc, e.due);
        end
      end
      if (DATA_VALID) begin
        if (dq.size() == 0) chk("data_unexpected", 32'(DATA_VALID), 32'd0);
        else begin
          e = dq.pop_front();
          chk("data_rdata", DATA_RDATA, e.rdata);
          chk("data_err", 32'(ACC_ERR), 32'(e.err));
          chk("data_cycle", cyc, e.due);
        end
      end
    end
  end

  // One request round from IDLE; data is modelled first since it wins arbitration.
  task automatic run_round(input bit do_i, input bit do_d, input bit d_we,
                           input logic [31:0] i_addr, input logic [31:0] d_addr,
                           input logic [31:0] d_wd, input logic [3:0] d_be, input bit early);
    exp_t        e;
    int unsigned start;
    bit          i_done, d_done;
    @(posedge CLK); #1;
    start = cyc;
    if (do_d) begin
      model_access(d_we, d_addr, d_wd, d_be, start + W + 1, e);
      dq.push_back(e);
      DATA_REQ = 1'b1; DATA_WRITE_ENABLE = d_we; DATA_ADDR = d_addr;
      DATA_WDATA = d_wd; DATA_BE = d_be;
    end
    if (do_i) begin
      model_access(1'b0, i_addr, '0, '0, do_d ? start + 2 * W + 4 : start + W + 1, e);
      iq.push_back(e);
      INSTR_REQ = 1'b1; INSTR_ADDR = i_addr;
    end
    i_done = !do_i;
    d_done = !do_d;
    for (int n = 0; n < 64 && !(i_done && d_done); n++) begin
      @(negedge CLK);
      if (INSTR_VALID) i_done = 1'b1;
      if (DATA_VALID)  d_done = 1'b1;
      @(posedge CLK); #1;
      if (i_done) INSTR_REQ = 1'b0;
      if (d_done) DATA_REQ = 1'b0;
      if (early && n == 0) begin
        DATA_REQ = 1'b0; DATA_ADDR = $urandom; DATA_WDATA = $urandom;
        DATA_BE = 4'($urandom); DATA_WRITE_ENABLE = ~DATA_WRITE_ENABLE;
      end
    end
    chk("round_complete", 32'(i_done && d_done), 32'd1);
    if (!(i_done && d_done)) begin
      iq.delete();
      dq.delete();
    end
    INSTR_REQ = 1'b0;
    DATA_REQ  = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge CLK);
  endtask

  // Reset pulsed while a store is waiting: everything clears, the store is lost.
  task automatic reset_mid_store(input logic [31:0] a);
    @(posedge CLK); #1;
    DATA_REQ = 1'b1; DATA_WRITE_ENABLE = 1'b1; DATA_ADDR = a;
    DATA_WDATA = ~ref_mem[a / 4]; DATA_BE = 4'hF;
    @(posedge CLK); #2;
    RES = 1'b1; DATA_REQ = 1'b0;
    #1;
    chk("rst_mid_instr_valid", 32'(INSTR_VALID), 32'd0);
    chk("rst_mid_data_valid", 32'(DATA_VALID), 32'd0);
    chk("rst_mid_acc_err", 32'(ACC_ERR), 32'd0);
    chk("rst_mid_instr_rdata", INSTR_RDATA, 32'd0);
    chk("rst_mid_data_rdata", DATA_RDATA, 32'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RES = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_instr_valid", 32'(INSTR_VALID), 32'd0);
    chk("reset_data_valid", 32'(DATA_VALID), 32'd0);
    chk("reset_acc_err", 32'(ACC_ERR), 32'd0);
    chk("reset_instr_rdata", INSTR_RDATA, 32'd0);
    chk("reset_data_rdata", DATA_RDATA, 32'd0);
    @(negedge CLK);
    RES = 1'b0;

    // Fill the modelled region through the store path.
    for (int k = 0; k < NWORDS; k++)
      run_round(1'b0, 1'b1, 1'b1, '0, 32'(k * 4), $urandom, 4'hF, 1'b0);

    // Fetch of RAM[3] = 0x13.
    run_round(1'b0, 1'b1, 1'b1, '0, 32'h0C, 32'h0000_0013, 4'hF, 1'b0);
    run_round(1'b1, 1'b0, 1'b0, 32'h0C, '0, '0, '0, 1'b0);
    // Partial store then load of word 4.
    run_round(1'b0, 1'b1, 1'b1, '0, 32'h10, 32'h1122_3344, 4'hF, 1'b0);
    run_round(1'b0, 1'b1, 1'b1, '0, 32'h10, 32'hAABB_CCDD, 4'b0011, 1'b0);
    run_round(1'b0, 1'b1, 1'b0, '0, 32'h10, '0, '0, 1'b0);
    // Contention, then a store racing a fetch of the same word.
    run_round(1'b1, 1'b1, 1'b0, 32'h0C, 32'h10, '0, '0, 1'b0);
    run_round(1'b1, 1'b1, 1'b1, 32'h10, 32'h10, 32'h5566_7788, 4'b1100, 1'b0);
    // Faulted stores and loads leave RAM untouched.
    run_round(1'b0, 1'b1, 1'b1, '0, 32'h11, 32'hDEAD_BEEF, 4'hF, 1'b0);
    run_round(1'b0, 1'b1, 1'b1, '0, 32'h0010_0000, 32'hDEAD_BEEF, 4'hF, 1'b0);
    run_round(1'b0, 1'b1, 1'b0, '0, 32'h10, '0, '0, 1'b0);
    run_round(1'b1, 1'b0, 1'b0, 32'h0010_0000, '0, '0, '0, 1'b0);
    // Request withdrawn during WAIT still completes with the latched values.
    run_round(1'b0, 1'b1, 1'b1, '0, 32'h20, 32'hCAFE_F00D, 4'hF, 1'b1);
    run_round(1'b0, 1'b1, 1'b0, '0, 32'h20, '0, '0, 1'b0);
    // Reset mid-store, then normal service.
    run_round(1'b1, 1'b1, 1'b0, 32'h0C, 32'h10, '0, '0, 1'b0);
    reset_mid_store(32'h14);
    run_round(1'b0, 1'b1, 1'b0, '0, 32'h14, '0, '0, 1'b0);

    for (int r = 0; r < 300; r++) begin
      int unsigned kind;
      kind = $urandom_range(0, 2);
      run_round(kind != 1, kind != 0, 1'($urandom), gen_addr(), gen_addr(),
                $urandom, 4'($urandom), ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(posedge CLK);
    chk("instr_queue_drained", 32'(iq.size()), 32'd0);
    chk("data_queue_drained", 32'(dq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
